// File: rtl/led_group_pkg.sv
// Shared types and helpers for the per-group LED controller.
package led_group_pkg;

    // Group modes; 2'b11 is unused and recovers to GRP_ON.
    typedef enum logic [1:0] {
        GRP_ON    = 2'b00,
        GRP_OFF   = 2'b01,
        GRP_BLINK = 2'b10
    } grp_state_t;

    localparam logic [1:0] GRP_ON_ENC    = 2'b00;
    localparam logic [1:0] GRP_OFF_ENC   = 2'b01;
    localparam logic [1:0] GRP_BLINK_ENC = 2'b10;

    // One step of the ON -> OFF -> BLINK -> ON cycle; illegal codes fall back to ON.
    function automatic logic [1:0] grp_advance(logic [1:0] cur, logic press);
        logic [1:0] nxt;
        nxt = GRP_ON_ENC;
        case (cur)
            GRP_ON_ENC:    nxt = press ? GRP_OFF_ENC   : GRP_ON_ENC;
            GRP_OFF_ENC:   nxt = press ? GRP_BLINK_ENC : GRP_OFF_ENC;
            GRP_BLINK_ENC: nxt = press ? GRP_ON_ENC    : GRP_BLINK_ENC;
            default:       nxt = GRP_ON_ENC;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-level debounce counter
// and rising-edge detector producing a one-cycle press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    // The accepting sample is the DEBOUNCE_CYCLES-th consecutive mismatch.
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            s1_q, s2_q;
    logic            db_q, db_n;
    logic            db_prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Debounce next state: any sample matching the accepted level restarts the count.
    always_comb begin
        db_n  = db_q;
        cnt_d = cnt_q;
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            db_n  = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser, debounce state and edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= btn_raw;
            s2_q      <= s1_q;
            db_q      <= db_n;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    assign level = db_q;
    assign press = db_q & ~db_prev_q;

endmodule

// File: rtl/led_group_ctrl.sv
// Switch-to-LED group controller: per-group debounced button stepping an
// ON/OFF/BLINK mode, one shared blink timebase, registered LED and state outputs.
module led_group_ctrl
    import led_group_pkg::*;
#(
    parameter int unsigned N_GROUPS        = 4,
    parameter int unsigned GROUP_W         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BLINK_HALF      = 25_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_GROUPS-1:0]           btn,
    input  logic [N_GROUPS*GROUP_W-1:0]   sw,
    output logic [N_GROUPS*GROUP_W-1:0]   led,
    output logic [2*N_GROUPS-1:0]         group_state
);

    localparam int unsigned BlinkW = $clog2(BLINK_HALF);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF - 1);

    logic [N_GROUPS-1:0]         press;
    logic [N_GROUPS-1:0]         db_level_unused;
    logic [N_GROUPS-1:0][1:0]    state_q, state_d;
    logic [BlinkW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                        blink_phase_q, blink_phase_d;
    logic [N_GROUPS*GROUP_W-1:0] led_q, led_d;
    logic [2*N_GROUPS-1:0]       group_state_q, group_state_d;

    for (genvar g = 0; g < N_GROUPS; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn[g]),
            .level  (db_level_unused[g]),
            .press  (press[g])
        );
    end

    // Group FSM next state: each group advances independently on its own press.
    always_comb begin
        state_d = state_q;
        for (int g = 0; g < N_GROUPS; g++) begin
            state_d[g] = grp_advance(state_q[g], press[g]);
        end
    end

    // Group FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    // Free-running blink timebase shared by all groups so they blink in phase.
    always_comb begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BlinkLast) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Blink timebase register; phase starts high so blinking groups light first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // LED and state output values derived from the current group modes.
    always_comb begin
        led_d         = '0;
        group_state_d = '0;
        for (int g = 0; g < N_GROUPS; g++) begin
            group_state_d[2*g +: 2] = state_q[g];
            case (state_q[g])
                GRP_ON_ENC:    led_d[g*GROUP_W +: GROUP_W] = sw[g*GROUP_W +: GROUP_W];
                GRP_BLINK_ENC: led_d[g*GROUP_W +: GROUP_W] =
                                   sw[g*GROUP_W +: GROUP_W] & {GROUP_W{blink_phase_q}};
                default:       led_d[g*GROUP_W +: GROUP_W] = '0;
            endcase
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q         <= '0;
            group_state_q <= '0;
        end else begin
            led_q         <= led_d;
            group_state_q <= group_state_d;
        end
    end

    assign led         = led_q;
    assign group_state = group_state_q;

endmodule

// File: tb/tb_led_group_ctrl.sv
// Self-checking bench for led_group_ctrl: directed scenarios plus random button
// and switch activity, all compared every cycle against a behavioural model.
module tb_led_group_ctrl;

    localparam int NG = 4;
    localparam int GW = 4;
    localparam int D  = 4;
    localparam int BH = 8;

    typedef logic [NG*GW-1:0] sw_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NG-1:0] btn = '0;
    sw_t           sw = '0;
    sw_t           led;
    logic [2*NG-1:0] group_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: raw samples delayed two edges, a run length of samples differing from
    // the accepted level, mode as 0/1/2, and edges since reset for the blink phase.
    int m_s1[NG], m_s2[NG], m_lvl[NG], m_prev[NG], m_run[NG], m_st[NG];
    int m_edges;

    led_group_ctrl #(
        .N_GROUPS       (NG),
        .GROUP_W        (GW),
        .DEBOUNCE_CYCLES(D),
        .BLINK_HALF     (BH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .sw         (sw),
        .led        (led),
        .group_state(group_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int g = 0; g < NG; g++) begin
            m_s1[g] = 0; m_s2[g] = 0; m_lvl[g] = 0; m_prev[g] = 0; m_run[g] = 0; m_st[g] = 0;
        end
        m_edges = 0;
    endtask

    // One clock: predict outputs from pre-edge model state, advance model, compare.
    task automatic step();
        sw_t             el;
        logic [2*NG-1:0] eg;
        int              ph;
        bit              pr;
        ph = 1 ^ ((m_edges / BH) % 2);
        el = '0;
        eg = '0;
        for (int g = 0; g < NG; g++) begin
            eg[2*g +: 2] = 2'(m_st[g]);
            if (m_st[g] == 0 || (m_st[g] == 2 && ph == 1)) el[g*GW +: GW] = sw[g*GW +: GW];
        end
        @(posedge clk);
        for (int g = 0; g < NG; g++) begin
            pr = (m_lvl[g] == 1 && m_prev[g] == 0);
            m_prev[g] = m_lvl[g];
            if (pr) m_st[g] = (m_st[g] + 1) % 3;
            if (m_s2[g] != m_lvl[g]) begin
                m_run[g]++;
                if (m_run[g] == D) begin
                    m_lvl[g] = m_s2[g];
                    m_run[g] = 0;
                end
            end else begin
                m_run[g] = 0;
            end
            m_s2[g] = m_s1[g];
            m_s1[g] = int'(btn[g]);
        end
        m_edges++;
        #1;
        check("led", 32'(led), 32'(el));
        check("group_state", 32'(group_state), 32'(eg));
        @(negedge clk);
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases at next negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_led", 32'(led), 32'h0);
        check("rst_group_state", 32'(group_state), 32'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press_btn(input int g, input int hold, input int gap);
        btn[g] = 1'b1;
        repeat (hold) step();
        btn[g] = 1'b0;
        repeat (gap) step();
    endtask

    initial begin
        model_clear();
        sw = 16'hFFFF;
        #2;
        do_reset();

        // Reset release: led follows sw after one edge.
        step();
        check("rst_release_led", 32'(led), 32'hFFFF);

        // Clean press on group 0: state change visible exactly at E7.
        btn[0] = 1'b1;
        repeat (7) step();
        check("press_e6_state", 32'(group_state[1:0]), 32'h0);
        step();
        check("press_e7_state", 32'(group_state[1:0]), 32'h1);
        check("press_e7_led", 32'(led), 32'hFFF0);
        repeat (4) step();
        btn[0] = 1'b0;
        repeat (12) step();
        check("release_no_change", 32'(group_state[1:0]), 32'h1);

        // Bounce on group 1: short pulses ignored, one advance once stable.
        btn[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0 && i % 2 == 0) btn[1] = ~btn[1];
            step();
        end
        btn[1] = 1'b1;
        repeat (12) step();
        btn[1] = 1'b0;
        repeat (12) step();
        check("bounce_one_advance", 32'(group_state[3:2]), 32'h1);

        // Full cycle on group 2.
        sw = 16'h0F00;
        press_btn(2, 12, 12);
        check("cycle_off_state", 32'(group_state[5:4]), 32'h1);
        check("cycle_off_led", 32'(led[11:8]), 32'h0);
        press_btn(2, 12, 24);
        check("cycle_blink_state", 32'(group_state[5:4]), 32'h2);
        press_btn(2, 12, 12);
        check("cycle_on_state", 32'(group_state[5:4]), 32'h0);
        check("cycle_on_led", 32'(led[11:8]), 32'hF);

        // Simultaneous presses on all groups.
        do_reset();
        sw = 16'hA5A5;
        btn = '1;
        repeat (12) step();
        btn = '0;
        repeat (12) step();
        check("simul_off_state", 32'(group_state), 32'h55);
        check("simul_off_led", 32'(led), 32'h0);
        btn = '1;
        repeat (12) step();
        btn = '0;
        repeat (20) step();
        check("simul_blink_state", 32'(group_state), 32'hAA);

        // Reset while blinking and with group 0 mid-debounce, button still held.
        btn[0] = 1'b1;
        repeat (4) step();
        do_reset();
        repeat (7) step();
        check("rst_mid_e6_state", 32'(group_state[1:0]), 32'h0);
        step();
        check("rst_mid_e7_state", 32'(group_state[1:0]), 32'h1);
        btn = '0;
        repeat (12) step();

        // Random button and switch activity.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) begin
                int idx;
                idx = int'($urandom_range(NG - 1));
                btn[idx] = ~btn[idx];
            end
            if ($urandom_range(3) == 0) sw = sw_t'($urandom);
            if ($urandom_range(249) == 0) do_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
